mem_bus_ctrl: RTL and testbench

- Parametrised memory-bus controller between the CPU memory port (mem_cmd/mem_addr/write_data/read_data) and the on-chip RAM plus memory-mapped I/O.
- Successor to the fixed 9-bit, single-region, tri-state read path.
- Decodes RAM, LED and switch regions, inserts RAM read-latency wait states, and returns a registered read_data with a one-cycle mem_ready handshake.
- Unmapped accesses are flagged.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/sync2.sv | 23 ++
 rtl/mem_bus_ctrl.sv | 106 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory-bus controller: bus commands, FSM states and
// the default I/O map.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory-port controller: decodes RAM / LED / switch regions, adds RAM
// read wait states and returns registered read data with a one-cycle ready.
module mem_bus_ctrl #(
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        RAM_AW   = 8,
  parameter int unsigned        RAM_LAT  = 1,
  parameter logic [ADDR_W-1:0]  LED_ADDR = ADDR_W'(mem_bus_pkg::LED_ADDR),
  parameter logic [ADDR_W-1:0]  SW_ADDR  = ADDR_W'(mem_bus_pkg::SW_ADDR),
  parameter int unsigned        LED_W    = 10,
  parameter int unsigned        SW_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  ledr
);

  import mem_bus_pkg::*;

  // Wide enough for RAM_LAT-1 with RAM_LAT up to 4.
  localparam int unsigned CNT_W = 2;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [SW_W-1:0]  sw_sync;

  logic is_ram, is_led, is_sw, is_rd, is_wr;

  assign is_ram = (mem_addr[ADDR_W-1:RAM_AW] == '0);
  assign is_led = (mem_addr == LED_ADDR);
  assign is_sw  = (mem_addr == SW_ADDR);
  assign is_rd  = (mem_cmd == MREAD);
  assign is_wr  = (mem_cmd == MWRITE);

  assign ram_addr  = mem_addr[RAM_AW-1:0];
  assign ram_din   = write_data;
  assign ram_write = (state == StIdle) && is_wr && is_ram;

  sync2 #(
    .WIDTH(SW_W)
  ) u_sw_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sw),
    .q    (sw_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      cnt       <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      ledr      <= '0;
    end else begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (is_rd && is_ram) begin
            state <= StWait;
            cnt   <= CNT_W'(RAM_LAT - 1);
          end else if (is_rd || is_wr) begin
            state     <= StResp;
            mem_ready <= 1'b1;
            if (is_ram) begin
              // RAM write already issued combinationally this cycle.
            end else if (is_led) begin
              if (is_wr) ledr      <= write_data[LED_W-1:0];
              else       read_data <= DATA_W'(ledr);
            end else if (is_sw) begin
              if (is_rd) read_data <= DATA_W'(sw_sync);
            end else begin
              read_data <= '0;
              bus_err   <= 1'b1;
            end
          end
        end
        StWait: begin
          if (cnt == '0) begin
            read_data <= ram_dout;
            state     <= StResp;
            mem_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        StResp: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: random and directed bus transactions
// checked against a map-level reference model.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int RAM_LAT = 3;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [9:0]  sw;
  logic [9:0]  ledr;

  mem_bus_ctrl #(
    .RAM_LAT(RAM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .mem_ready (mem_ready),
    .bus_err   (bus_err),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .sw        (sw),
    .ledr      (ledr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // RAM device attached to the controller; unwritten words read as init_val.
  logic [15:0] ram [256];
  logic        ram_vld [256];
  always @(posedge clk) begin
    if (ram_write) begin
      ram[ram_addr]     <= ram_din;
      ram_vld[ram_addr] <= 1'b1;
    end
    ram_dout <= ram_vld[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
  end

  // Reference model state.
  logic [15:0] mem_m [256];
  logic [9:0]  ledr_m;
  logic [9:0]  sw_m;
  logic [15:0] last_rd;

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a transaction.
  always @(negedge clk) begin
    exp_t e;
    if (reset && mem_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got ready=1 expected ready=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("read_data", 32'(read_data), 32'(e.rd));
        chk("bus_err", 32'(bus_err), 32'(e.err));
        chk("ready_cycle", cyc, e.cyc);
      end
    end else if (reset && bus_err) begin
      checks++;
      failures++;
      $display("FAIL stray_bus_err: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic do_tx(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    exp_t e;
    bit   is_ram, is_led, is_sw, got;
    int   lat;
    is_ram = (addr < 9'd256);
    is_led = (addr == 9'h100);
    is_sw  = (addr == 9'h140);
    e.err  = 1'b0;
    lat    = 1;
    if (cmd == MREAD) begin
      if (is_ram) begin
        last_rd = mem_m[addr[7:0]];
        lat     = RAM_LAT + 1;
      end else if (is_led) last_rd = {6'd0, ledr_m};
      else if (is_sw)      last_rd = {6'd0, sw_m};
      else begin
        last_rd = '0;
        e.err   = 1'b1;
      end
    end else begin
      if (is_ram)      mem_m[addr[7:0]] = data;
      else if (is_led) ledr_m = data[9:0];
      else if (!is_sw) begin
        last_rd = '0;
        e.err   = 1'b1;
      end
    end
    e.rd = last_rd;
    @(negedge clk);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    e.cyc      = cyc + lat;
    sb.push_back(e);
    #1;
    chk("ram_write_accept", 32'(ram_write), 32'((cmd == MWRITE) && is_ram));
    if (is_ram) chk("ram_addr", 32'(ram_addr), 32'(addr[7:0]));
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) got = 1'b1;
      else chk("ram_write_quiet", 32'(ram_write), 32'd0);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got no ready expected ready by cycle %0d", e.cyc);
      sb.delete();
    end
    mem_cmd = MNONE;
    chk("ledr", 32'(ledr), 32'(ledr_m));
  endtask

  task automatic set_sw(input logic [9:0] v);
    @(negedge clk);
    sw   = v;
    sw_m = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic illegal_cmd(input logic [8:0] addr);
    @(negedge clk);
    mem_cmd    = 2'b11;
    mem_addr   = addr;
    write_data = 16'hFFFF;
    #1;
    chk("ram_write_cmd11", 32'(ram_write), 32'd0);
    @(negedge clk);
    mem_cmd = MNONE;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    mem_cmd  = MREAD;
    mem_addr = 9'h0FF;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    mem_cmd = MNONE;
    ledr_m  = '0;
    last_rd = '0;
    @(negedge clk);
    chk("rst_mid_read_data", 32'(read_data), 32'd0);
    chk("rst_mid_ledr", 32'(ledr), 32'd0);
    chk("rst_mid_ready", 32'(mem_ready), 32'd0);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_ready", 32'(mem_ready), 32'd0);
    end
    do_tx(MREAD, 9'h0FF, 16'h0);
  endtask

  initial begin
    logic [8:0] a;
    for (int i = 0; i < 256; i++) begin
      mem_m[i]   = init_val(i);
      ram_vld[i] = 1'b0;
    end
    reset      = 1'b0;
    mem_cmd    = MREAD;
    mem_addr   = 9'h000;
    write_data = 16'h0;
    sw         = 10'h3FF;
    sw_m       = 10'h3FF;
    ledr_m     = '0;
    last_rd    = '0;
    repeat (3) @(negedge clk);
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    mem_cmd = MNONE;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_read_data", 32'(read_data), 32'd0);
    chk("rel_ledr", 32'(ledr), 32'd0);
    chk("rel_ready", 32'(mem_ready), 32'd0);
    chk("rel_ram_write", 32'(ram_write), 32'd0);

    do_tx(MWRITE, 9'h005, 16'hABCD);
    do_tx(MREAD, 9'h005, 16'h0);
    chk("ram_rd_abcd", 32'(read_data), 32'h0000ABCD);
    do_tx(MREAD, 9'h0FF, 16'h0);
    do_tx(MWRITE, 9'h100, 16'h02A5);
    chk("led_2a5", 32'(ledr), 32'h2A5);
    do_tx(MREAD, 9'h100, 16'h0);
    chk("led_rd", 32'(read_data), 32'h02A5);
    set_sw(10'h155);
    do_tx(MREAD, 9'h140, 16'h0);
    chk("sw_rd", 32'(read_data), 32'h0155);
    do_tx(MREAD, 9'h1F0, 16'h0);
    do_tx(MWRITE, 9'h140, 16'hFFFF);
    do_tx(MWRITE, 9'h1F0, 16'h1234);
    illegal_cmd(9'h010);
    reset_mid_op();

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0: set_sw(10'($urandom));
        1: illegal_cmd(9'($urandom_range(0, 255)));
        default: begin
          case ($urandom_range(0, 4))
            0, 1: a = 9'($urandom_range(0, 255));
            2: a = 9'h100;
            3: a = 9'h140;
            default: begin
              a = 9'($urandom_range(256, 511));
              if (a == 9'h100 || a == 9'h140) a = 9'h1FF;
            end
          endcase
          do_tx($urandom_range(0, 1) ? MREAD : MWRITE, a, 16'($urandom));
        end
      endcase
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
